// File: rtl/lap_history_char_rom.sv
// lap_history_char_rom: captures lap times, converts to M:SS:CC and serves text cells for history + best rows
module lap_history_char_rom #(
  parameter int NUM_LAPS = 3,
  parameter int TIME_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lap_done,
  input  logic [TIME_W-1:0] lap_time,
  input  logic [15:0]       char_xy,
  output logic [6:0]        char_code,
  output logic              busy,
  output logic              overrun
);
  typedef enum logic [1:0] {IDLE, CONV, STORE} state_t;
  state_t                       state_q, state_d;
  logic [15:0]                  rem_q, rem_d, cur_q, cur_d, best_bin_q, best_bin_d;
  logic [15:0]                  pend_t_q, pend_t_d, t_in, src, w;
  logic [2:0]                   idx_q, idx_d;
  logic [4:0][3:0]              dig_q, dig_d, best_q, best_d, sel;
  logic [NUM_LAPS-1:0][4:0][3:0] hist_q, hist_d;
  logic [NUM_LAPS-1:0]          valid_q, valid_d;
  logic                         best_v_q, best_v_d, pend_v_q, pend_v_d, ovr_q, ovr_d, start, sel_v, is_best;
  logic [6:0]                   char_q, char_d;
  logic [7:0]                   col, row;

  function automatic logic [6:0] dch(input logic v, input logic [3:0] d);
    return v ? {3'b011, d} : 7'h2D;
  endfunction

  assign t_in = (lap_time >= TIME_W'(60000)) ? 16'd59999 : lap_time[15:0];
  assign w = (idx_q == 3'd0) ? 16'd6000 : (idx_q == 3'd1) ? 16'd1000 :
             (idx_q == 3'd2) ? 16'd100  : (idx_q == 3'd3) ? 16'd10 : 16'd1;
  assign col = char_xy[15:8];
  assign row = char_xy[7:0];

  // Converter FSM, pending slot, history shift and best tracking
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    cur_d      = cur_q;
    idx_d      = idx_q;
    dig_d      = dig_q;
    hist_d     = hist_q;
    valid_d    = valid_q;
    best_d     = best_q;
    best_v_d   = best_v_q;
    best_bin_d = best_bin_q;
    pend_v_d   = pend_v_q;
    pend_t_d   = pend_t_q;
    ovr_d      = 1'b0;
    start      = 1'b0;
    src        = t_in;
    case (state_q)
      IDLE: start = lap_done;
      CONV: begin
        if (rem_q >= w) begin
          rem_d        = rem_q - w;
          dig_d[idx_q] = dig_q[idx_q] + 4'd1;
        end else if (idx_q == 3'd4) state_d = STORE;
        else idx_d = idx_q + 3'd1;
        if (lap_done) begin
          pend_v_d = 1'b1;
          pend_t_d = t_in;
          ovr_d    = pend_v_q;
        end
      end
      default: begin
        hist_d[0]  = dig_q;
        valid_d[0] = 1'b1;
        for (int i = 1; i < NUM_LAPS; i++) begin
          hist_d[i]  = hist_q[i-1];
          valid_d[i] = valid_q[i-1];
        end
        if (!best_v_q || cur_q < best_bin_q) begin
          best_d     = dig_q;
          best_bin_d = cur_q;
          best_v_d   = 1'b1;
        end
        state_d  = IDLE;
        start    = pend_v_q || lap_done;
        src      = pend_v_q ? pend_t_q : t_in;
        pend_v_d = pend_v_q && lap_done;
        pend_t_d = t_in;
      end
    endcase
    if (start) begin
      state_d = CONV;
      rem_d   = src;
      cur_d   = src;
      idx_d   = 3'd0;
      dig_d   = '0;
    end
  end

  // Text cell lookup for the addressed row/column
  always_comb begin
    sel   = best_q;
    sel_v = best_v_q;
    for (int i = 0; i < NUM_LAPS; i++)
      if (row == 8'(i)) begin
        sel   = hist_q[i];
        sel_v = valid_q[i];
      end
    is_best = row == 8'(NUM_LAPS);
    char_d  = 7'h00;
    if (row <= 8'(NUM_LAPS))
      case (col)
        8'd0:  char_d = is_best ? 7'h42 : 7'h4C;
        8'd1:  char_d = is_best ? 7'h45 : 7'h41;
        8'd2:  char_d = is_best ? 7'h53 : 7'h50;
        8'd3:  char_d = is_best ? 7'h54 : 7'h31 + row[6:0];
        8'd4, 8'd7, 8'd10: char_d = 7'h3A;
        8'd5:  char_d = 7'h20;
        8'd6:  char_d = dch(sel_v, sel[0]);
        8'd8:  char_d = dch(sel_v, sel[1]);
        8'd9:  char_d = dch(sel_v, sel[2]);
        8'd11: char_d = dch(sel_v, sel[3]);
        8'd12: char_d = dch(sel_v, sel[4]);
        default: char_d = 7'h00;
      endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      cur_q      <= '0;
      idx_q      <= '0;
      dig_q      <= '0;
      hist_q     <= '0;
      valid_q    <= '0;
      best_q     <= '0;
      best_v_q   <= 1'b0;
      best_bin_q <= '0;
      pend_v_q   <= 1'b0;
      pend_t_q   <= '0;
      ovr_q      <= 1'b0;
      char_q     <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      cur_q      <= cur_d;
      idx_q      <= idx_d;
      dig_q      <= dig_d;
      hist_q     <= hist_d;
      valid_q    <= valid_d;
      best_q     <= best_d;
      best_v_q   <= best_v_d;
      best_bin_q <= best_bin_d;
      pend_v_q   <= pend_v_d;
      pend_t_q   <= pend_t_d;
      ovr_q      <= ovr_d;
      char_q     <= char_d;
    end
  end

  assign char_code = char_q;
  assign busy      = state_q != IDLE;
  assign overrun   = ovr_q;
endmodule

// File: tb/tb_lap_history_char_rom.sv
// tb_lap_history_char_rom: directed checks of capture, conversion timing, history, best and text output
module tb_lap_history_char_rom;
  logic        clk = 1'b0;
  logic        rst_n, lap_done;
  logic [15:0] lap_time, char_xy;
  logic [6:0]  char_code;
  logic        busy, overrun;
  int          checks = 0, failures = 0, n, ovr_cnt;

  lap_history_char_rom #(.NUM_LAPS(3), .TIME_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .lap_done(lap_done), .lap_time(lap_time),
    .char_xy(char_xy), .char_code(char_code), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic rd(input string tag, input int c, input int r, input int exp);
    char_xy = {8'(c), 8'(r)};
    step();
    chk(tag, int'(char_code), exp);
  endtask

  task automatic chk_row(input string tag, input int r, input logic [103:0] exp);
    logic [103:0] got;
    got = '0;
    for (int c = 0; c < 13; c++) begin
      char_xy = {8'(c), 8'(r)};
      step();
      got = {got[95:0], 1'b0, char_code};
    end
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=\"%s\" exp=\"%s\"", tag, got, exp);
    end
  endtask

  task automatic wait_idle();
    n = 0;
    ovr_cnt = 0;
    while (busy && n < 200) begin
      ovr_cnt += int'(overrun);
      n++;
      step();
    end
  endtask

  task automatic lap(input string tag, input int t, input int exp_busy);
    lap_done = 1'b1;
    lap_time = 16'(t);
    step();
    lap_done = 1'b0;
    wait_idle();
    chk(tag, n, exp_busy);
  endtask

  initial begin
    rst_n = 1'b0;
    lap_done = 1'b0;
    lap_time = '0;
    char_xy = '0;
    repeat (3) step();
    chk("rst_char", int'(char_code), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovr", int'(overrun), 0);
    rst_n = 1'b1;
    rd("rst_dash", 6, 0, 'h2D);
    rd("rst_B", 0, 3, 'h42);
    rd("rst_out", 20, 0, 'h00);
    rd("rst_row4", 0, 4, 'h00);

    lap("busy_12345", 12345, 20);
    chk_row("row0_12345", 0, "LAP1: 2:03:45");
    chk_row("best_12345", 3, "BEST: 2:03:45");
    chk_row("row1_empty", 1, "LAP2: -:--:--");

    lap("busy_5000", 5000, 11);
    lap("busy_4000", 4000, 10);
    lap("busy_4500", 4500, 15);
    lap("busy_9000", 9000, 10);
    chk_row("hist_r0", 0, "LAP1: 1:30:00");
    chk_row("hist_r1", 1, "LAP2: 0:45:00");
    chk_row("hist_r2", 2, "LAP3: 0:40:00");
    chk_row("hist_best", 3, "BEST: 0:40:00");

    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    lap("busy_clamp", 65535, 47);
    chk_row("clamp_r0", 0, "LAP1: 9:59:99");
    chk_row("clamp_best", 3, "BEST: 9:59:99");
    lap("busy_tie", 59999, 47);
    chk_row("tie_r1", 1, "LAP2: 9:59:99");
    chk_row("tie_best", 3, "BEST: 9:59:99");

    lap_done = 1'b1;
    lap_time = 16'd100;
    step();
    chk("ovr_s0", int'(overrun), 0);
    chk("busy_s0", int'(busy), 1);
    lap_time = 16'd200;
    step();
    chk("ovr_s1", int'(overrun), 0);
    lap_time = 16'd300;
    step();
    lap_done = 1'b0;
    chk("ovr_s2", int'(overrun), 1);
    wait_idle();
    chk("ovr_count", ovr_cnt, 1);
    chk("busy_b2b", n, 14);
    chk_row("pend_r0", 0, "LAP1: 0:03:00");
    chk_row("pend_r1", 1, "LAP2: 0:01:00");
    chk_row("pend_r2", 2, "LAP3: 9:59:99");

    lap_done = 1'b1;
    lap_time = 16'd12345;
    step();
    lap_done = 1'b0;
    repeat (5) step();
    chk("busy_midconv", int'(busy), 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_char", int'(char_code), 0);
    chk_row("mid_rst_r0", 0, "LAP1: -:--:--");
    chk_row("mid_rst_r1", 1, "LAP2: -:--:--");
    chk_row("mid_rst_r2", 2, "LAP3: -:--:--");
    chk_row("mid_rst_best", 3, "BEST: -:--:--");
    chk("mid_rst_idle", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
